// File: rtl/fifo_rd_serializer.sv
// Purpose: pops 128-bit words from a synchronous FIFO and emits them as narrow beats, LSB first.
// Latency: rden one cycle after an eligible IDLE cycle; beat 0 valid three cycles after it.
// Backpressure: i_ready low freezes the current beat (data/last/valid held); no new read until the word drains.
module fifo_rd_serializer #(
   parameter int DATA_WIDTH = 128,
   parameter int OUT_WIDTH  = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_en,
   input  logic                  i_fifo_empty,
   output logic                  o_fifo_rden,
   input  logic [DATA_WIDTH-1:0] i_fifo_rddata,
   output logic [OUT_WIDTH-1:0]  o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_last,
   output logic                  o_busy,
   output logic [CNT_WIDTH-1:0]  o_word_cnt
);

   localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   // Reject geometries where a word does not split into at least two whole beats.
   if ((DATA_WIDTH % OUT_WIDTH) != 0 || BEATS < 2) begin : g_bad_geometry
      $error("fifo_rd_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      CAP  = 2'd2,
      SEND = 2'd3
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic [IDX_W-1:0]      idx_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  beat_hs;
   logic                  last_hs;

   // All outputs are decoded from registers only; i_ready never reaches o_valid/o_data.
   assign o_valid     = (state_q == SEND);
   assign o_fifo_rden = (state_q == RD);
   assign o_busy      = (state_q != IDLE);
   assign o_last      = o_valid && (idx_q == LAST_IDX);
   assign o_data      = shreg_q[OUT_WIDTH-1:0];
   assign o_word_cnt  = cnt_q;

   assign beat_hs = o_valid && i_ready;
   assign last_hs = beat_hs && (idx_q == LAST_IDX);

   // State register; reset abandons any word in flight.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: only the IDLE exit is gated by i_en and the empty flag.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (i_en && !i_fifo_empty) begin
               state_d = RD;
            end
         end
         RD: begin
            // Read data arrives one cycle after rden; empty is ignored here.
            state_d = CAP;
         end
         CAP: begin
            state_d = SEND;
         end
         SEND: begin
            if (last_hs) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Word capture and LSB-first shifting; index tracks which beat is on the bus.
   always_ff @(posedge clk) begin
      if (rstn) begin
         shreg_q <= '0;
         idx_q   <= '0;
      end else if (state_q == CAP) begin
         shreg_q <= i_fifo_rddata;
         idx_q   <= '0;
      end else if (beat_hs) begin
         shreg_q <= shreg_q >> OUT_WIDTH;
         if (!last_hs) begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

   // Drained-word counter bumps on the edge that accepts a word's final beat; wraps naturally.
   always_ff @(posedge clk) begin
      if (rstn) begin
         cnt_q <= '0;
      end else if (last_hs) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

endmodule

// File: doc/fifo_rd_serializer.md
# fifo_rd_serializer

Read-side drain stage placed directly downstream of the 128-bit synchronous FIFO. It pops one word at a time through the FIFO's read-enable/read-data port and splits each word into narrow beats. The beats go out on a valid/ready stream, with a last-beat marker and a running count of drained words. It absorbs the FIFO's one-cycle read latency and its lagging empty flag, so downstream logic sees a clean stream.

## Interface
- DATA_WIDTH, 128, FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 32, output beat width.
- BEATS, DATA_WIDTH/OUT_WIDTH (derived, localparam), beats per word; must be ≥2.
- CNT_WIDTH, 16, width of the drained-word counter.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rstn  input  1  reset is synchronous and active-high (asserted = 1).
- i_en  input  1  1 = allowed to start a new FIFO read.
- i_fifo_empty  input  1  FIFO empty flag.
- o_fifo_rden  output  1  FIFO read enable, one-cycle pulse per word.
- i_fifo_rddata  input  DATA_WIDTH  FIFO read data, valid the cycle after the rden pulse.
- o_data  output  OUT_WIDTH  current beat.
- o_valid  output  1  beat valid.
- i_ready  input  1  downstream accepts the beat when o_valid && i_ready.
- o_last  output  1  high with the final beat (index BEATS-1) of a word.
- o_busy  output  1  high whenever the state is not IDLE.
- o_word_cnt  output  CNT_WIDTH  number of words whose last beat has been accepted.

## Operation
- Reset values:
  - o_fifo_rden=0, o_valid=0, o_data=0, o_last=0, o_busy=0, o_word_cnt=0.
  - Shift register = 0, beat index = 0, state = IDLE.
- FSM states are IDLE, RD, CAP, SEND.
  - IDLE: if i_en && !i_fifo_empty, go to RD; otherwise stay.
  - RD: o_fifo_rden=1 for exactly this cycle. Always go to CAP; i_fifo_empty is ignored here.
  - CAP: load i_fifo_rddata into the shift register, clear the beat index, go to SEND.
  - SEND: o_valid=1, o_data = the beat slice, o_last = (index == BEATS-1).
    - On handshake with index < BEATS-1: increment the index and stay in SEND.
    - On handshake of the last beat: o_word_cnt += 1 (wraps modulo 2^CNT_WIDTH), then go to IDLE.
- Beat order is LSB first. Beat k = word[k*OUT_WIDTH +: OUT_WIDTH].
- While o_valid=1 and i_ready=0, o_data and o_last hold stable and o_valid is never withdrawn.
- Deasserting i_en blocks only the IDLE→RD transition. A word already in RD, CAP or SEND completes normally.
- o_fifo_rden is a Moore output: it is asserted only in RD, so at most one pulse per word.
- Minimum spacing between rden pulses is BEATS+3 cycles, which exceeds the FIFO's empty-flag lag of 2 cycles. A stale empty=0 can therefore never cause a read of an empty FIFO.
- Reset asserted mid-word: the FSM returns to IDLE on the next edge. The popped word is discarded and its remaining beats are never sent. o_word_cnt clears to 0.

## Timing
- Let cycle t be an IDLE cycle with i_en=1 and i_fifo_empty=0. Then:
  - o_fifo_rden=1 in cycle t+1.
  - Capture occurs at the end of t+2.
  - Beat 0 is valid in t+3.
- With i_ready held at 1, beat k is in t+3+k, and o_last=1 in t+3+BEATS-1.
- With i_ready=1 and a non-empty FIFO, the throughput is one word per BEATS+3 cycles: 7 cycles with the defaults.
- o_busy rises in t+1 and falls in the cycle after the last handshake.
- o_word_cnt updates on the same edge that accepts the last beat.
- Output-to-input: no combinational path from i_ready to o_valid or o_data. i_ready only gates register updates.

## Test plan
- Reset, then FIFO holds one word 0x44444444_33333333_22222222_11111111, i_ready=1 → one rden pulse; o_data = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on four consecutive cycles; o_last only on the 4th beat; o_word_cnt=1.
- 10 words written (FIFO full), i_ready=1 → exactly 10 rden pulses spaced ≥7 cycles; 40 beats in order; o_word_cnt=10; no rden after the FIFO reports empty.
- Random i_ready backpressure (50%) on 3 words → every beat holds stable while stalled; no beat lost or duplicated; o_word_cnt=3.
- i_en=0 with a non-empty FIFO for 20 cycles → no rden, o_busy=0. i_en dropped mid-word → that word finishes (4 beats), then the block idles.
- rstn pulsed during beat 2 of a word → next cycle o_valid=0, o_busy=0, o_word_cnt=0; the next word starts cleanly from beat 0.
- Counter wrap: set CNT_WIDTH=2 and drain 5 words → o_word_cnt sequence 1, 2, 3, 0, 1.
